// File: rtl/sprite_mem_writer.sv
// CPU-side write/readback port into the 4-bit sprite pixel RAM; one 32-bit bus word = 8 pixels.
// Optional readback path enabled by defining SPRITE_MEM_READBACK_EN.
module sprite_mem_writer #(
   parameter int unsigned ADDR_BITS = 14,
   parameter int unsigned PIX_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 iomem_valid,
   output logic                 iomem_ready,
   input  logic [3:0]           iomem_wstrb,
   input  logic [31:0]          iomem_addr,
   input  logic [31:0]          iomem_wdata,
   output logic [31:0]          iomem_rdata,
   output logic                 spr_we,
   output logic [ADDR_BITS-1:0] spr_addr,
   output logic [PIX_BITS-1:0]  spr_wdata,
   input  logic [PIX_BITS-1:0]  spr_rdata
);

   localparam int unsigned IDX_BITS = ADDR_BITS - 3;

`ifdef SPRITE_MEM_READBACK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_e;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_DONE = 2'd3} state_e;
`endif

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [IDX_BITS-1:0]   idx_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  ready_q;
   logic [31:0]           rdata_q;
   logic                  we_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [PIX_BITS-1:0]   pix_q;

   // Byte-offset and upper address bits alias onto the same word.
   logic unused_c;
`ifdef SPRITE_MEM_READBACK_EN
   assign unused_c = ^{iomem_addr[31:ADDR_BITS-1], iomem_addr[1:0]};
`else
   assign unused_c = ^{iomem_addr[31:ADDR_BITS-1], iomem_addr[1:0], spr_rdata};
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         ready_q <= 1'b0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         pix_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // ready_q high means the previous request is still being acknowledged
               if (iomem_valid && !ready_q) begin
                  idx_q   <= iomem_addr[ADDR_BITS-2:2];
                  wdata_q <= iomem_wdata;
                  wstrb_q <= iomem_wstrb;
                  cnt_q   <= 4'd0;
                  if (iomem_wstrb != 4'd0) begin
                     state_q <= ST_WRITE;
                  end else begin
`ifdef SPRITE_MEM_READBACK_EN
                     state_q <= ST_READ;
                     addr_q  <= {iomem_addr[ADDR_BITS-2:2], 3'd0};
`else
                     state_q <= ST_DONE;
`endif
                  end
               end
            end
            ST_WRITE: begin
               addr_q  <= {idx_q, cnt_q[2:0]};
               pix_q   <= wdata_q[32'(cnt_q[2:0]) * PIX_BITS +: PIX_BITS];
               we_q    <= wstrb_q[cnt_q[2:1]];
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'd7) state_q <= ST_DONE;
            end
`ifdef SPRITE_MEM_READBACK_EN
            // Address leads capture by one cycle to cover the RAM read latency.
            ST_READ: begin
               if (cnt_q != 4'd0)
                  rdata_q[32'(3'(cnt_q - 4'd1)) * PIX_BITS +: PIX_BITS] <= spr_rdata;
               if (cnt_q < 4'd7)
                  addr_q <= {idx_q, 3'(cnt_q + 4'd1)};
               if (cnt_q == 4'd8) state_q <= ST_DONE;
               else               cnt_q   <= cnt_q + 4'd1;
            end
`endif
            ST_DONE: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign spr_we      = we_q;
   assign spr_addr    = addr_q;
   assign spr_wdata   = pix_q;

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Directed bench for sprite_mem_writer with a behavioural 16384x4 synchronous pixel RAM.
module tb_sprite_mem_writer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        spr_we;
   logic [13:0] spr_addr;
   logic [3:0]  spr_wdata;
   logic [3:0]  spr_rdata;

   logic [3:0]  mem [0:16383];
   int          n_cmp = 0;
   int          n_err = 0;
   int          we_cnt = 0;

   always #5 clk = ~clk;

   sprite_mem_writer dut (
      .clk(clk), .resetn(resetn),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .spr_we(spr_we), .spr_addr(spr_addr),
      .spr_wdata(spr_wdata), .spr_rdata(spr_rdata)
   );

   always @(posedge clk) begin
      if (spr_we === 1'b1) begin
         mem[spr_addr] <= spr_wdata;
         we_cnt <= we_cnt + 1;
      end
      spr_rdata <= mem[spr_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request; returns posedges from first valid edge to ready, and rdata seen with ready.
   task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit hold, output int lat, output logic [31:0] rd);
      bit seen;
      @(negedge clk);
      iomem_addr = a; iomem_wdata = d; iomem_wstrb = s; iomem_valid = 1'b1;
      lat = 0; seen = 0;
      while (lat < 40 && !seen) begin
         @(posedge clk); #1;
         lat++;
         if (!hold) iomem_valid = 1'b0;
         if (iomem_ready) seen = 1;
      end
      rd = iomem_rdata;
      @(negedge clk);
      iomem_valid = 1'b0;
   endtask

   initial begin
      int          lat;
      int          we0;
      int          gap;
      logic [31:0] rd;
      logic [13:0] last_addr;

      for (int i = 0; i < 16384; i++) mem[i] = 4'd0;
      resetn = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
      iomem_addr = 32'd0; iomem_wdata = 32'd0;
      #3 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(iomem_ready), 32'd0);
      check("rst_rdata", iomem_rdata, 32'd0);
      check("rst_we",    32'(spr_we), 32'd0);
      check("rst_addr",  32'(spr_addr), 32'd0);
      check("rst_wdata", 32'(spr_wdata), 32'd0);
      @(negedge clk) resetn = 1'b1;

      // Full-strobe write to word 0x10
      we0 = we_cnt;
      do_txn(32'h0000_0040, 32'h7654_3210, 4'hF, 1'b1, lat, rd);
      check("wr_full_lat", 32'(lat), 32'd10);
      check("wr_full_wecnt", 32'(we_cnt - we0), 32'd8);
      for (int k = 0; k < 8; k++) check("wr_full_pix", 32'(mem[14'h080 + 14'(k)]), 32'(k));
      check("wr_full_last_addr", 32'(spr_addr), 32'h087);
      check("wr_full_we_idle", 32'(spr_we), 32'd0);

      // Partial strobes at word 0: pixels 0,1,4,5 only
      we0 = we_cnt;
      do_txn(32'h0000_0000, 32'hFEDC_BA98, 4'b0101, 1'b1, lat, rd);
      check("wr_part_lat", 32'(lat), 32'd10);
      check("wr_part_wecnt", 32'(we_cnt - we0), 32'd4);
      check("wr_part_p0", 32'(mem[0]), 32'h8);
      check("wr_part_p1", 32'(mem[1]), 32'h9);
      check("wr_part_p2", 32'(mem[2]), 32'h0);
      check("wr_part_p3", 32'(mem[3]), 32'h0);
      check("wr_part_p4", 32'(mem[4]), 32'hC);
      check("wr_part_p5", 32'(mem[5]), 32'hD);
      check("wr_part_p7", 32'(mem[7]), 32'h0);
      check("wr_part_last_addr", 32'(spr_addr), 32'h007);

      // Readback
      last_addr = spr_addr;
      we0 = we_cnt;
`ifdef SPRITE_MEM_READBACK_EN
      do_txn(32'h0000_0040, 32'h0, 4'h0, 1'b1, lat, rd);
      check("rd_lat", 32'(lat), 32'd11);
      check("rd_data", rd, 32'h7654_3210);
      do_txn(32'h0000_6040, 32'h0, 4'h0, 1'b1, lat, rd);
      check("rd_alias_data", rd, 32'h7654_3210);
      do_txn(32'h0000_0000, 32'h0, 4'h0, 1'b1, lat, rd);
      check("rd_part_data", rd, 32'h00DC_0098);
      check("rd_no_we", 32'(we_cnt - we0), 32'd0);
`else
      do_txn(32'h0000_0040, 32'h0, 4'h0, 1'b1, lat, rd);
      check("rd_off_lat", 32'(lat), 32'd2);
      check("rd_off_data", rd, 32'd0);
      check("rd_off_addr", 32'(spr_addr), 32'(last_addr));
      check("rd_off_no_we", 32'(we_cnt - we0), 32'd0);
`endif

      // Valid pulsed for one cycle only: transaction still completes
      do_txn(32'h0000_0004, 32'h0000_00F0, 4'b0001, 1'b0, lat, rd);
      check("pulse_lat", 32'(lat), 32'd10);
      check("pulse_p9", 32'(mem[9]), 32'hF);
      check("pulse_p8", 32'(mem[8]), 32'h0);

      // Back-to-back with valid held across ready; 0x2044 aliases to word 0x11
      we0 = we_cnt;
      @(negedge clk);
      iomem_addr = 32'h0000_2044; iomem_wdata = 32'hA5A5_A5A5; iomem_wstrb = 4'hF;
      iomem_valid = 1'b1;
      lat = 0;
      while (lat < 40 && !iomem_ready) begin @(posedge clk); #1; lat++; end
      check("b2b_first_lat", 32'(lat), 32'd10);
      gap = 0;
      do begin @(posedge clk); #1; gap++; end while (gap < 40 && !iomem_ready);
      check("b2b_gap", 32'(gap), 32'd11);
      @(negedge clk) iomem_valid = 1'b0;
      gap = 0;
      repeat (20) begin @(posedge clk); #1; if (iomem_ready) gap++; end
      check("b2b_no_extra_ready", 32'(gap), 32'd0);
      check("b2b_wecnt", 32'(we_cnt - we0), 32'd16);
      check("b2b_p88", 32'(mem[14'h088]), 32'h5);
      check("b2b_p8f", 32'(mem[14'h08F]), 32'hA);

      // Reset in the middle of a write to word 0x20
      @(negedge clk);
      iomem_addr = 32'h0000_0080; iomem_wdata = 32'h3333_3333; iomem_wstrb = 4'hF;
      iomem_valid = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0; iomem_valid = 1'b0;
      #1;
      check("mid_rst_we", 32'(spr_we), 32'd0);
      check("mid_rst_ready", 32'(iomem_ready), 32'd0);
      check("mid_rst_rdata", iomem_rdata, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      check("mid_rst_p100", 32'(mem[14'h100]), 32'h3);
      check("mid_rst_p102", 32'(mem[14'h102]), 32'h3);
      check("mid_rst_p103", 32'(mem[14'h103]), 32'h0);

      // Fresh write after release shows the FSM restarted from idle
      do_txn(32'h0000_0084, 32'h1234_5678, 4'hF, 1'b1, lat, rd);
      check("post_rst_lat", 32'(lat), 32'd10);
      check("post_rst_p108", 32'(mem[14'h108]), 32'h8);
      check("post_rst_p10f", 32'(mem[14'h10F]), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
